hazard_unit: RTL and testbench

Pipeline hazard and halt controller for the five-stage CPU, sitting in ID directly upstream of the EX-stage forwarding unit. Each cycle it decides whether the PC and IF/ID register advance and whether IF/ID is flushed. It also decides whether ID/EX receives a bubble instead of the decoded instruction. It covers the hazards that forwarding cannot resolve:

- load-use
- BR register dependence
- conditional-branch flag dependence
- HLT drain

---
 rtl/hazard_unit.sv | 102 ++++++++++
 tb/tb_hazard_unit.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// Hazard and halt controller for the five-stage pipeline: load-use, BR register,
// branch-flag stalls and the HLT drain into a sticky halted state.
module hazard_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  Rs_ID,
  input  logic [3:0]  Rt_ID,
  input  logic        UsesRs_ID,
  input  logic        UsesRt_ID,
  input  logic        Branch_ID,
  input  logic        BranchReg_ID,
  input  logic        BranchTaken_ID,
  input  logic        Halt_ID,
  input  logic        MemRead_EX,
  input  logic        RegWrite_EX,
  input  logic        FlagWrite_EX,
  input  logic [3:0]  Rd_EX,
  input  logic        RegWrite_MEM,
  input  logic [3:0]  Rd_MEM,
  input  logic        MemStall,
  output logic        PCWrite,
  output logic        IFID_Write,
  output logic        IFID_Flush,
  output logic        IDEX_Bubble,
  output logic        Halted,
  output logic [15:0] StallCount
);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t     state, stateNext;
  logic [1:0] drainCnt, drainCntNext;
  logic       loadUse, brReg, brFlag, stall;
  logic       rdExLive, rdMemLive;

  // Register 0 never carries a dependence.
  assign rdExLive  = (Rd_EX  != 4'd0);
  assign rdMemLive = (Rd_MEM != 4'd0);

  assign loadUse = MemRead_EX & rdExLive &
                   ((UsesRs_ID & (Rd_EX == Rs_ID)) | (UsesRt_ID & (Rd_EX == Rt_ID)));
  assign brReg   = BranchReg_ID &
                   ((RegWrite_EX  & rdExLive  & (Rd_EX  == Rs_ID)) |
                    (RegWrite_MEM & rdMemLive & (Rd_MEM == Rs_ID)));
  assign brFlag  = Branch_ID & FlagWrite_EX;
  assign stall   = loadUse | brReg | brFlag;

  always_comb begin
    stateNext    = state;
    drainCntNext = drainCnt;
    PCWrite      = 1'b0;
    IFID_Write   = 1'b0;
    IFID_Flush   = 1'b0;
    IDEX_Bubble  = 1'b0;
    if (rst) begin
      IFID_Flush  = 1'b1;
      IDEX_Bubble = 1'b1;
    end else if (MemStall) begin
      // Pipeline frozen externally: hold everything.
    end else begin
      case (state)
        HALTED: ;
        DRAIN: begin
          IDEX_Bubble  = 1'b1;
          drainCntNext = drainCnt + 2'd1;
          if (drainCnt == 2'd2) stateNext = HALTED;
        end
        default: begin
          if (stall) begin
            IDEX_Bubble = 1'b1;
          end else if (Halt_ID) begin
            IFID_Write   = 1'b1;
            IFID_Flush   = 1'b1;
            stateNext    = DRAIN;
            drainCntNext = 2'd0;
          end else begin
            PCWrite    = 1'b1;
            IFID_Write = 1'b1;
            IFID_Flush = BranchTaken_ID;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      drainCnt   <= 2'd0;
      Halted     <= 1'b0;
      StallCount <= 16'd0;
    end else if (!MemStall) begin
      state    <= stateNext;
      drainCnt <= drainCntNext;
      // Halted trails the HALTED state by one edge.
      if (state == HALTED) Halted <= 1'b1;
      if (state == RUN && stall && StallCount != 16'hFFFF)
        StallCount <= StallCount + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: combinational vector table plus multi-cycle
// sequences for stalls, HLT drain with MemStall, reset recovery and saturation.
module tb_hazard_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  Rs_ID, Rt_ID, Rd_EX, Rd_MEM;
  logic        UsesRs_ID, UsesRt_ID, Branch_ID, BranchReg_ID, BranchTaken_ID, Halt_ID;
  logic        MemRead_EX, RegWrite_EX, FlagWrite_EX, RegWrite_MEM, MemStall;
  logic        PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble, Halted;
  logic [15:0] StallCount;

  int checks = 0;
  int errors = 0;

  hazard_unit dut (
    .clk(clk), .rst(rst), .Rs_ID(Rs_ID), .Rt_ID(Rt_ID),
    .UsesRs_ID(UsesRs_ID), .UsesRt_ID(UsesRt_ID), .Branch_ID(Branch_ID),
    .BranchReg_ID(BranchReg_ID), .BranchTaken_ID(BranchTaken_ID), .Halt_ID(Halt_ID),
    .MemRead_EX(MemRead_EX), .RegWrite_EX(RegWrite_EX), .FlagWrite_EX(FlagWrite_EX),
    .Rd_EX(Rd_EX), .RegWrite_MEM(RegWrite_MEM), .Rd_MEM(Rd_MEM), .MemStall(MemStall),
    .PCWrite(PCWrite), .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush),
    .IDEX_Bubble(IDEX_Bubble), .Halted(Halted), .StallCount(StallCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] rs, rt, rdEx, rdMem;
    logic       usesRs, usesRt, br, brReg, taken, halt;
    logic       memRead, regWrEx, flagWrEx, regWrMem, memStall;
    logic [3:0] expCtl;  // {PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble}
  } vec_t;

  vec_t vecs[14];

  function automatic logic [3:0] ctl();
    return {PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble};
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    Rs_ID = 0; Rt_ID = 0; Rd_EX = 0; Rd_MEM = 0;
    UsesRs_ID = 0; UsesRt_ID = 0; Branch_ID = 0; BranchReg_ID = 0;
    BranchTaken_ID = 0; Halt_ID = 0; MemRead_EX = 0; RegWrite_EX = 0;
    FlagWrite_EX = 0; RegWrite_MEM = 0; MemStall = 0;
  endtask

  task automatic apply(input vec_t v);
    Rs_ID = v.rs; Rt_ID = v.rt; Rd_EX = v.rdEx; Rd_MEM = v.rdMem;
    UsesRs_ID = v.usesRs; UsesRt_ID = v.usesRt; Branch_ID = v.br;
    BranchReg_ID = v.brReg; BranchTaken_ID = v.taken; Halt_ID = v.halt;
    MemRead_EX = v.memRead; RegWrite_EX = v.regWrEx; FlagWrite_EX = v.flagWrEx;
    RegWrite_MEM = v.regWrMem; MemStall = v.memStall;
  endtask

  task automatic doReset();
    @(negedge clk); idle(); rst = 1;
    @(negedge clk); rst = 0;
  endtask

  task automatic loadUse3();
    idle(); MemRead_EX = 1; Rd_EX = 3; UsesRs_ID = 1; Rs_ID = 3;
  endtask

  initial begin
    //         name       rs rt rdEx rdMem uRs uRt br brR tk ht mR rWE fWE rWM mS  exp
    vecs[0]  = '{"idle",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1100};
    vecs[1]  = '{"luRs",     3, 0, 3, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 4'b0001};
    vecs[2]  = '{"luRt",     0, 7, 7, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 4'b0001};
    vecs[3]  = '{"luR0",     0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 4'b1100};
    vecs[4]  = '{"luNoUse",  3, 3, 3, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 4'b1100};
    vecs[5]  = '{"aluFwd",   3, 0, 3, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 4'b1100};
    vecs[6]  = '{"brrEx",    5, 0, 5, 0, 1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 4'b0001};
    vecs[7]  = '{"brrMem",   5, 0, 0, 5, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 4'b0001};
    vecs[8]  = '{"brrR0",    0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 1, 0, 1, 0, 4'b1100};
    vecs[9]  = '{"brFlag",   0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0, 4'b0001};
    vecs[10] = '{"taken",    0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 4'b1110};
    vecs[11] = '{"msLu",     3, 0, 3, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 4'b0000};
    vecs[12] = '{"msTaken",  0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 1, 4'b0000};
    vecs[13] = '{"haltStall",3, 0, 3, 0, 1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 4'b0001};

    idle(); rst = 1;
    @(negedge clk); @(negedge clk);
    chk("rstCtl", {12'd0, ctl()}, 16'h0003);
    chk("rstHalted", {15'd0, Halted}, 16'd0);
    chk("rstCount", StallCount, 16'd0);
    rst = 0;

    foreach (vecs[i]) begin
      @(negedge clk); apply(vecs[i]); #1;
      chk(vecs[i].name, {12'd0, ctl()}, {12'd0, vecs[i].expCtl});
    end

    // Load-use then normal cycle
    doReset();
    loadUse3(); #1; chk("luStall", {12'd0, ctl()}, 16'h0001);
    @(negedge clk); idle(); #1; chk("luAfter", {12'd0, ctl()}, 16'h000C);
    chk("luCount", StallCount, 16'd1);

    // Register-0 filter leaves count alone
    MemRead_EX = 1; UsesRs_ID = 1; #1; chk("r0Ctl", {12'd0, ctl()}, 16'h000C);
    @(negedge clk); idle(); chk("r0Count", StallCount, 16'd1);

    // BR after ADD R5: two stall cycles, then taken flush
    BranchReg_ID = 1; UsesRs_ID = 1; Rs_ID = 5; RegWrite_EX = 1; Rd_EX = 5; #1;
    chk("brr1", {12'd0, ctl()}, 16'h0001);
    @(negedge clk); RegWrite_EX = 0; Rd_EX = 0; RegWrite_MEM = 1; Rd_MEM = 5; #1;
    chk("brr2", {12'd0, ctl()}, 16'h0001);
    @(negedge clk); RegWrite_MEM = 0; Rd_MEM = 0; BranchTaken_ID = 1; #1;
    chk("brrTaken", {12'd0, ctl()}, 16'h000E);
    @(negedge clk); idle(); chk("brrCount", StallCount, 16'd3);

    // Flag stall beats taken branch
    Branch_ID = 1; FlagWrite_EX = 1; BranchTaken_ID = 1; #1;
    chk("flagStall", {12'd0, ctl()}, 16'h0001);
    @(negedge clk); FlagWrite_EX = 0; #1;
    chk("flagFlush", {12'd0, ctl()}, 16'h000E);

    // Three more load-use cycles -> count 7
    @(negedge clk); loadUse3();
    repeat (3) @(negedge clk);
    idle(); chk("count7", StallCount, 16'd7);

    // HLT with MemStall on two drain cycles: Halted after edge 6
    Halt_ID = 1; #1; chk("hltAccept", {12'd0, ctl()}, 16'h0006);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk); idle();
      MemStall = (k == 1 || k == 3);
      #1;
      if (k <= 5)
        chk($sformatf("drainCtl%0d", k), {12'd0, ctl()}, MemStall ? 16'h0000 : 16'h0001);
      @(posedge clk); #1;
      chk($sformatf("halted%0d", k), {15'd0, Halted}, {15'd0, (k >= 6)});
    end
    @(negedge clk); idle(); BranchTaken_ID = 1; Halt_ID = 1; #1;
    chk("haltedCtl", {12'd0, ctl()}, 16'h0000);
    loadUse3(); #1; chk("haltedCtl2", {12'd0, ctl()}, 16'h0000);
    @(negedge clk); chk("haltedCount", StallCount, 16'd7);
    chk("haltedSticky", {15'd0, Halted}, 16'd1);

    // Reset recovery from HALTED
    idle(); rst = 1; #1; chk("rstCtl2", {12'd0, ctl()}, 16'h0003);
    @(negedge clk); rst = 0; #1;
    chk("recHalted", {15'd0, Halted}, 16'd0);
    chk("recCount", StallCount, 16'd0);
    chk("recPC", {15'd0, PCWrite}, 16'd1);

    // Saturation
    @(negedge clk); loadUse3();
    repeat (65534) @(negedge clk);
    chk("cntFFFE", StallCount, 16'hFFFE);
    repeat (3) @(negedge clk);
    chk("cntSat", StallCount, 16'hFFFF);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
